// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its instruction memory/execute stage.
// The master side is the sequencer; the slave side is memory plus datapath.
interface pc_sequencer_if;
    // Instruction fetch handshake
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Issue towards decode/execute
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;

    // Next-PC control from the datapath
    logic [1:0]  pcsrc;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic        stall;

    // Status
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
               pc, pc_plus4, misaligned, retired,
        input  imem_ack, imem_rdata, exec_done, pcsrc,
               br_target, jalr_target, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
               pc, pc_plus4, misaligned, retired,
        output imem_ack, imem_rdata, exec_done, pcsrc,
               br_target, jalr_target, stall
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots, fetches one instruction at a time,
// issues it for one cycle, waits for the execute stage and then computes the
// next PC. A next PC with bit 1 set is a fault that parks the sequencer in
// HALT until reset.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr, instr_nxt;
    logic [31:0] retired, retired_nxt;
    logic        misaligned, misaligned_nxt;
    // Set once the fetch of the current FETCH visit has been acknowledged
    // while a stall held us in FETCH; the request must not be repeated.
    logic        fetched, fetched_nxt;
    logic [31:0] target;

    // Next-PC candidate selected by the datapath's pcsrc
    always_comb begin
        target = pc + 32'd4;
        unique case (bus.pcsrc)
            2'b01:   target = bus.br_target;
            2'b10:   target = {bus.jalr_target[31:1], 1'b0};
            default: target = pc + 32'd4;
        endcase
    end

    // Next-state and next-register logic; everything holds unless updated
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        instr_nxt      = instr;
        retired_nxt    = retired;
        misaligned_nxt = misaligned;
        fetched_nxt    = fetched;

        unique case (state)
            BOOT: begin
                if (!bus.stall) begin
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                if (!fetched) begin
                    // An acknowledge is always captured, even under stall;
                    // only the move to ISSUE waits for the stall to clear.
                    if (bus.imem_ack) begin
                        instr_nxt = bus.imem_rdata;
                        if (bus.stall) begin
                            fetched_nxt = 1'b1;
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end
                end else if (!bus.stall) begin
                    fetched_nxt = 1'b0;
                    state_nxt   = ISSUE;
                end
            end

            ISSUE: begin
                if (!bus.stall) begin
                    state_nxt = EXEC;
                end
            end

            EXEC: begin
                // Stall wins over exec_done; the execute stage re-asserts it.
                if (bus.exec_done && !bus.stall) begin
                    retired_nxt = retired + 32'd1;
                    if (target[1]) begin
                        misaligned_nxt = 1'b1;
                        state_nxt      = HALT;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end
                end
            end

            HALT: begin
                state_nxt = HALT;
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State and architectural registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            instr      <= 32'd0;
            retired    <= 32'd0;
            misaligned <= 1'b0;
            fetched    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            instr      <= instr_nxt;
            retired    <= retired_nxt;
            misaligned <= misaligned_nxt;
            fetched    <= fetched_nxt;
        end
    end

    // Request is decoded from state, so reset drops it immediately.
    assign bus.imem_req    = (state == FETCH) && !fetched;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    // The issue strobe is the ISSUE state, masked on cycles the datapath
    // freezes us so it fires exactly once, on the first unstalled cycle.
    assign bus.instr_valid = (state == ISSUE) && !bus.stall;
    assign bus.pc          = pc;
    assign bus.pc_plus4    = pc + 32'd4;
    assign bus.misaligned  = misaligned;
    assign bus.retired     = retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table covering the
// sequential, branch, JALR, stall, ignore and misalignment flows, plus a
// hand-written sequence on a second instance for PC wrap and mid-fetch reset.
module tb_pc_sequencer;

    localparam logic [31:0] I0 = 32'h0000_0013;
    localparam logic [31:0] I1 = 32'h0010_0093;
    localparam logic [31:0] I2 = 32'h0020_0113;
    localparam logic [31:0] I3 = 32'h1000_006F;
    localparam logic [31:0] I4 = 32'h1040_0067;
    localparam logic [31:0] I5 = 32'h0E00_006F;
    localparam logic [31:0] JK = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;
    logic rst2_n;

    pc_sequencer_if bus ();
    pc_sequencer_if bus2 ();

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        done;
        logic [1:0]  pcsrc;
        logic [31:0] br;
        logic [31:0] jalr;
        logic        req;
        logic [31:0] addr;
        logic        ivld;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] ret;
        logic [31:0] instr;
    } vec_t;

    vec_t vt[$];
    int   n_cmp;
    int   n_err;

    function automatic vec_t mk(
        logic r, logic s, logic a, logic [31:0] rd, logic d, logic [1:0] ps,
        logic [31:0] b, logic [31:0] j,
        logic q, logic iv, logic [31:0] p, logic m, logic [31:0] rt, logic [31:0] in
    );
        vec_t v;
        v.rst_n = r;  v.stall = s;  v.ack = a;   v.rdata = rd;
        v.done  = d;  v.pcsrc = ps; v.br = b;    v.jalr = j;
        v.req   = q;  v.addr  = p;  v.ivld = iv; v.pc = p;
        v.mis   = m;  v.ret   = rt; v.instr = in;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        bus.imem_ack = 1'b0;  bus.imem_rdata = '0;  bus.exec_done = 1'b0;
        bus.pcsrc = 2'b00;    bus.br_target = '0;   bus.jalr_target = '0;
        bus.stall = 1'b0;
        bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.exec_done = 1'b0;
        bus2.pcsrc = 2'b00;   bus2.br_target = '0;  bus2.jalr_target = '0;
        bus2.stall = 1'b0;

        //          rst stl ack rdata done pcsrc br             jalr           req ivld pc             mis ret    instr
        vt.push_back(mk(0, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0000, 0, 32'd0, '0)); // 0 reset
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0000, 0, 32'd0, '0)); // 1 BOOT
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_0000, 0, 32'd0, '0)); // 2 FETCH wait
        vt.push_back(mk(1, 0, 1, I0, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_0000, 0, 32'd0, '0)); // 3 FETCH ack
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 1, 32'h0000_0000, 0, 32'd0, I0)); // 4 ISSUE
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0000, 0, 32'd0, I0)); // 5 EXEC wait
        vt.push_back(mk(1, 0, 0, '0, 1, 2'b00, '0,            '0,            0, 0, 32'h0000_0000, 0, 32'd0, I0)); // 6 EXEC done +4
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_0004, 0, 32'd1, I0)); // 7 FETCH 4
        vt.push_back(mk(1, 0, 1, I1, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_0004, 0, 32'd1, I0)); // 8 ack
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 1, 32'h0000_0004, 0, 32'd1, I1)); // 9 ISSUE
        vt.push_back(mk(1, 0, 0, '0, 1, 2'b11, 32'h0000_0400, 32'h0000_0500, 0, 0, 32'h0000_0004, 0, 32'd1, I1)); // 10 done, pcsrc 11
        vt.push_back(mk(1, 0, 1, I2, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_0008, 0, 32'd2, I1)); // 11 FETCH 8 ack
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 1, 32'h0000_0008, 0, 32'd2, I2)); // 12 ISSUE
        vt.push_back(mk(1, 0, 0, '0, 1, 2'b00, '0,            '0,            0, 0, 32'h0000_0008, 0, 32'd2, I2)); // 13 done +4
        vt.push_back(mk(1, 0, 1, I3, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_000C, 0, 32'd3, I2)); // 14 FETCH C ack
        vt.push_back(mk(1, 1, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_000C, 0, 32'd3, I3)); // 15 ISSUE stall
        vt.push_back(mk(1, 1, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_000C, 0, 32'd3, I3)); // 16 ISSUE stall
        vt.push_back(mk(1, 1, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_000C, 0, 32'd3, I3)); // 17 ISSUE stall
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 1, 32'h0000_000C, 0, 32'd3, I3)); // 18 ISSUE go
        vt.push_back(mk(1, 1, 0, '0, 1, 2'b01, 32'h0000_0100, '0,            0, 0, 32'h0000_000C, 0, 32'd3, I3)); // 19 done+stall
        vt.push_back(mk(1, 0, 0, '0, 1, 2'b01, 32'h0000_0100, '0,            0, 0, 32'h0000_000C, 0, 32'd3, I3)); // 20 branch
        vt.push_back(mk(1, 1, 1, I4, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_0100, 0, 32'd4, I3)); // 21 ack under stall
        vt.push_back(mk(1, 1, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0100, 0, 32'd4, I4)); // 22 held in FETCH
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0100, 0, 32'd4, I4)); // 23 release
        vt.push_back(mk(1, 0, 1, JK, 0, 2'b00, '0,            '0,            0, 1, 32'h0000_0100, 0, 32'd4, I4)); // 24 ISSUE, stray ack
        vt.push_back(mk(1, 0, 0, '0, 1, 2'b10, 32'h0000_0300, 32'h0000_0205, 0, 0, 32'h0000_0100, 0, 32'd4, I4)); // 25 JALR
        vt.push_back(mk(1, 0, 1, I5, 1, 2'b01, 32'h0000_0800, '0,            1, 0, 32'h0000_0204, 0, 32'd5, I4)); // 26 FETCH, stray done
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 1, 32'h0000_0204, 0, 32'd5, I5)); // 27 ISSUE
        vt.push_back(mk(1, 0, 0, '0, 1, 2'b01, 32'h0000_0102, '0,            0, 0, 32'h0000_0204, 0, 32'd5, I5)); // 28 misaligned branch
        vt.push_back(mk(1, 0, 1, JK, 1, 2'b00, '0,            '0,            0, 0, 32'h0000_0204, 1, 32'd6, I5)); // 29 HALT
        vt.push_back(mk(1, 1, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0204, 1, 32'd6, I5)); // 30 HALT
        vt.push_back(mk(0, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0000, 0, 32'd0, '0)); // 31 reset
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            0, 0, 32'h0000_0000, 0, 32'd0, '0)); // 32 BOOT
        vt.push_back(mk(1, 0, 0, '0, 0, 2'b00, '0,            '0,            1, 0, 32'h0000_0000, 0, 32'd0, '0)); // 33 FETCH 0

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst_n            = vt[i].rst_n;
            bus.stall        = vt[i].stall;
            bus.imem_ack     = vt[i].ack;
            bus.imem_rdata   = vt[i].rdata;
            bus.exec_done    = vt[i].done;
            bus.pcsrc        = vt[i].pcsrc;
            bus.br_target    = vt[i].br;
            bus.jalr_target  = vt[i].jalr;
            #1;
            chk($sformatf("v%0d imem_req", i),    {31'd0, bus.imem_req},    {31'd0, vt[i].req});
            chk($sformatf("v%0d imem_addr", i),   bus.imem_addr,            vt[i].addr);
            chk($sformatf("v%0d instr_valid", i), {31'd0, bus.instr_valid}, {31'd0, vt[i].ivld});
            chk($sformatf("v%0d pc", i),          bus.pc,                   vt[i].pc);
            chk($sformatf("v%0d pc_plus4", i),    bus.pc_plus4,             vt[i].pc + 32'd4);
            chk($sformatf("v%0d misaligned", i),  {31'd0, bus.misaligned},  {31'd0, vt[i].mis});
            chk($sformatf("v%0d retired", i),     bus.retired,              vt[i].ret);
            chk($sformatf("v%0d instr", i),       bus.instr,                vt[i].instr);
        end

        // Second instance: PC wrap from 0xFFFF_FFFC, then reset mid-fetch.
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        chk("wrap boot pc", bus2.pc, 32'hFFFF_FFFC);
        chk("wrap boot pc_plus4", bus2.pc_plus4, 32'h0000_0000);
        @(negedge clk);
        bus2.imem_ack = 1'b1;
        bus2.imem_rdata = I0;
        #1;
        chk("wrap fetch req", {31'd0, bus2.imem_req}, 32'd1);
        chk("wrap fetch addr", bus2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        bus2.imem_ack = 1'b0;
        #1;
        chk("wrap issue valid", {31'd0, bus2.instr_valid}, 32'd1);
        @(negedge clk);
        bus2.exec_done = 1'b1;
        bus2.pcsrc = 2'b00;
        @(negedge clk);
        bus2.exec_done = 1'b0;
        #1;
        chk("wrap next addr", bus2.imem_addr, 32'h0000_0000);
        chk("wrap next req", {31'd0, bus2.imem_req}, 32'd1);
        chk("wrap no fault", {31'd0, bus2.misaligned}, 32'd0);
        chk("wrap retired", bus2.retired, 32'd1);

        // Reset in the middle of the fetch cycle, acknowledge still pending
        #2;
        rst2_n = 1'b0;
        #1;
        chk("midreset req drop", {31'd0, bus2.imem_req}, 32'd0);
        chk("midreset pc", bus2.pc, 32'hFFFF_FFFC);
        chk("midreset retired", bus2.retired, 32'd0);
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        #1;
        chk("restart req", {31'd0, bus2.imem_req}, 32'd1);
        chk("restart addr", bus2.imem_addr, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
